// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - request/response bundle for the iterative shift unit
//
// Signals:
//   start  : operation request, sampled only while the unit is idle
//   op     : 00 SLL, 01 SRL, 10 SRA, 11 ROTL
//   a      : operand
//   shamt  : shift amount, 0..WIDTH-1
//   clear  : synchronous abort of an in-flight operation
//   result : registered result, held until the next completion
//   busy   : operation in flight
//   done   : one-cycle pulse when result updates
// Modports: master (requester side), slave (shift unit side).

interface iter_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               clear;
    logic [WIDTH-1:0]   result;
    logic               busy;
    logic               done;

    modport master (
        output start, op, a, shamt, clear,
        input  result, busy, done
    );

    modport slave (
        input  start, op, a, shamt, clear,
        output result, busy, done
    );
endinterface

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle SLL/SRL/SRA/ROTL unit shifting at most STEP bits per clock
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : iter_shifter_if.slave (start/op/a/shamt/clear in, result/busy/done out)

module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic           clk,
    input  logic           reset,
    iter_shifter_if.slave  bus
);
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROTL} op_t;

    // One extra bit so STEP == WIDTH and WIDTH itself are representable.
    localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W + 1)'(WIDTH);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W:0]   rk;
    logic [WIDTH-1:0]   shifted;

    // Step amount k = min(rem, STEP). When STEP == WIDTH the truncated
    // STEP_W slice is 0 but is never selected, because rem < WIDTH always.
    always_comb begin
        k       = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHAMT_W-1:0];
        rk      = WIDTH_W - {1'b0, k};
        shifted = data_q;
        case (op_q)
            OP_SLL:  shifted = data_q << k;
            OP_SRL:  shifted = data_q >> k;
            // Sign bit is never disturbed by an arithmetic step, so the
            // fill stays equal to the original operand MSB across steps.
            OP_SRA:  shifted = WIDTH'($signed(data_q) >>> k);
            // k == 0 makes data_q >> WIDTH, which is 0, so ROTL by 0 is identity.
            OP_ROTL: shifted = (data_q << k) | (data_q >> rk);
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.clear) begin
                    data_d  = bus.a;
                    rem_d   = bus.shamt;
                    op_d    = op_t'(bus.op);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Abort wins over a completion falling on the same edge.
                if (bus.clear) begin
                    state_d = S_IDLE;
                end else if (rem_q != '0) begin
                    data_d = shifted;
                    rem_d  = rem_q - k;
                end else begin
                    result_d = data_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            data_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q == S_BUSY);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter

module tb_iter_shifter;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a negedge with the unit idle, scramble the
    // inputs right after accept, and wait (bounded) for done.
    // lat = edges from accept edge to done visible, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [4:0] s,
                          output int lat, output int busy_cnt);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.shamt = s;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0; bus.op = ~o; bus.a = 32'hDEAD_BEEF; bus.shamt = 5'd7;
        lat = -1; busy_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; bus.start = 1'b1; bus.clear = 1'b0;
        bus.op = 2'b00; bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd3;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); @(negedge clk);
            total_cnt++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); else pass_cnt++;
            total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
            total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else pass_cnt++;
        end
        bus.start = 1'b0; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_no_accept: got busy %b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_sll;
        int lat, bc;
        run_op(2'b00, 32'h0000_0001, 5'd31, lat, bc);
        total_cnt++; if (lat !== 9) $display("FAIL sll31_latency: got %0d expected 9", lat); else pass_cnt++;
        total_cnt++; if (bc !== 9) $display("FAIL sll31_busy_cycles: got %0d expected 9", bc); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h8000_0000) $display("FAIL sll31_result: got %h expected %h", bus.result, 32'h8000_0000); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL done_single_pulse: got %b expected 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h8000_0000) $display("FAIL result_hold: got %h expected %h", bus.result, 32'h8000_0000); else pass_cnt++;
        run_op(2'b00, 32'h0000_0001, 5'd5, lat, bc);
        total_cnt++; if (lat !== 3) $display("FAIL sll5_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0020) $display("FAIL sll5_result: got %h expected %h", bus.result, 32'h0000_0020); else pass_cnt++;
    endtask

    task automatic test_sra_srl;
        int lat, bc;
        run_op(2'b10, 32'h8000_00F0, 5'd4, lat, bc);
        total_cnt++; if (lat !== 2) $display("FAIL sra4_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'hF800_000F) $display("FAIL sra4_result: got %h expected %h", bus.result, 32'hF800_000F); else pass_cnt++;
        run_op(2'b01, 32'h8000_00F0, 5'd4, lat, bc);
        total_cnt++; if (lat !== 2) $display("FAIL srl4_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0800_000F) $display("FAIL srl4_result: got %h expected %h", bus.result, 32'h0800_000F); else pass_cnt++;
        run_op(2'b10, 32'h8000_0000, 5'd31, lat, bc);
        total_cnt++; if (lat !== 9) $display("FAIL sra31_latency: got %0d expected 9", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'hFFFF_FFFF) $display("FAIL sra31_result: got %h expected %h", bus.result, 32'hFFFF_FFFF); else pass_cnt++;
        run_op(2'b01, 32'hF000_0000, 5'd30, lat, bc);
        total_cnt++; if (bus.result !== 32'h0000_0003) $display("FAIL srl30_result: got %h expected %h", bus.result, 32'h0000_0003); else pass_cnt++;
    endtask

    task automatic test_rotl_zero;
        int lat, bc;
        run_op(2'b11, 32'h8000_0001, 5'd1, lat, bc);
        total_cnt++; if (lat !== 2) $display("FAIL rotl1_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0003) $display("FAIL rotl1_result: got %h expected %h", bus.result, 32'h0000_0003); else pass_cnt++;
        run_op(2'b11, 32'h8000_0001, 5'd4, lat, bc);
        total_cnt++; if (bus.result !== 32'h0000_0018) $display("FAIL rotl4_result: got %h expected %h", bus.result, 32'h0000_0018); else pass_cnt++;
        run_op(2'b11, 32'hC000_0001, 5'd31, lat, bc);
        total_cnt++; if (bus.result !== 32'hE000_0000) $display("FAIL rotl31_result: got %h expected %h", bus.result, 32'hE000_0000); else pass_cnt++;
        run_op(2'b10, 32'h1234_5678, 5'd0, lat, bc);
        total_cnt++; if (lat !== 1) $display("FAIL zero_latency: got %0d expected 1", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h1234_5678) $display("FAIL zero_result: got %h expected %h", bus.result, 32'h1234_5678); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int lat;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0000_0001; bus.shamt = 5'd8;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.shamt = 5'd0;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin lat = i; break; end
        end
        total_cnt++; if (lat !== 3) $display("FAIL ignore_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0100) $display("FAIL ignore_result: got %h expected %h", bus.result, 32'h0000_0100); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL ignore_no_second_op: got busy %b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0000_0003; bus.shamt = 5'd4;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin lat = i; break; end
        end
        total_cnt++; if (lat !== 3) $display("FAIL b2b_first_latency: got %0d expected 3", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0030) $display("FAIL b2b_first_result: got %h expected %h", bus.result, 32'h0000_0030); else pass_cnt++;
        bus.op = 2'b01; bus.a = 32'h0000_0005; bus.shamt = 5'd2;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", bus.busy); else pass_cnt++;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin lat = i; break; end
        end
        total_cnt++; if (lat !== 2) $display("FAIL b2b_second_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0001) $display("FAIL b2b_second_result: got %h expected %h", bus.result, 32'h0000_0001); else pass_cnt++;
    endtask

    task automatic test_clear;
        int lat, bc, seen;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h0000_FFFF; bus.shamt = 5'd20;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.clear = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL clear_busy: got %b expected 0", bus.busy); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) seen++;
            @(posedge clk); @(negedge clk);
        end
        total_cnt++; if (seen !== 0) $display("FAIL clear_no_done: got %0d pulses expected 0", seen); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_0001) $display("FAIL clear_result_kept: got %h expected %h", bus.result, 32'h0000_0001); else pass_cnt++;
        bus.start = 1'b1; bus.clear = 1'b1; bus.shamt = 5'd0;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0; bus.clear = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL clear_idle_blocks_start: got busy %b expected 0", bus.busy); else pass_cnt++;
        run_op(2'b01, 32'h0000_00F0, 5'd4, lat, bc);
        total_cnt++; if (lat !== 2) $display("FAIL after_clear_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0000_000F) $display("FAIL after_clear_result: got %h expected %h", bus.result, 32'h0000_000F); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1; bus.shamt = 5'd16;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.result !== 32'h0) $display("FAIL midreset_result: got %h expected %h", bus.result, 32'h0); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", bus.done); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b0; bus.start = 1'b0; bus.clear = 1'b0;
        bus.op = 2'b00; bus.a = '0; bus.shamt = '0;
        @(negedge clk);
        test_reset;
        test_sll;
        test_sra_srl;
        test_rotl_zero;
        test_ignore_start;
        test_back_to_back;
        test_clear;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Multi-cycle, parametrised shift unit for the CPU datapath.
- Generalises the fixed left-shift-by-2 used in branch-offset generation to variable-amount SLL/SRL/SRA/ROTL.
- Shifts by at most STEP bits per clock, trading latency for area.
- Uses a start/busy/done handshake so the stall controller can hold the pipeline while it is busy.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, ≥ 4.
- SHAMT_W, $clog2(WIDTH) (5), width of the shift-amount input.
- STEP, 4, maximum bits shifted per clock; power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL; latched at accept.
- a  input  WIDTH  operand; latched at accept.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; latched at accept.
- clear  input  1  synchronous abort of an in-flight operation.
- result  output  WIDTH  registered result; held until the next completion.
- busy  output  1  high while an operation is in flight (BUSY state).
- done  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset (reset==0 at an edge):
  - state←IDLE, result←0, busy←0, done←0, internal data/rem←0.
  - Takes priority over clear and start.
- States: IDLE, BUSY. busy is 1 exactly when state==BUSY, and is registered.
- IDLE, start==1, clear==0 at an edge:
  - data←a, rem←shamt, op latched.
  - state←BUSY, done←0.
- IDLE, otherwise: hold; done←0.
- BUSY, rem≠0, each edge:
  - k = min(rem, STEP); data←shift(data, op, k); rem←rem−k.
- Shift rules for shift(data, op, k):
  - SLL: zero fill at LSBs.
  - SRL: zero fill at MSBs.
  - SRA: fill with data[WIDTH-1]; the MSB is preserved through steps, so the fill equals the original a[WIDTH-1].
  - ROTL: bits leaving MSB re-enter at LSB.
- BUSY, rem==0 at an edge: result←data, done←1, state←IDLE.
- Latency:
  - start-accept edge to done visible = ceil(shamt/STEP)+1 cycles.
  - shamt==0 gives done one cycle after accept, with result==a.
- start in BUSY is ignored; the requester must hold start until it sees busy==0.
- Back-to-back: start is accepted in the same cycle done==1, because state is already IDLE there.
- Inputs a/op/shamt may change freely after the accept edge without affecting the in-flight operation.
- clear==1 in BUSY:
  - state←IDLE, result unchanged, done←0, no completion pulse.
  - clear wins over a simultaneous internal completion.
- clear==1 in IDLE: start is not accepted that cycle.
- reset deasserted mid-operation:
  - Any reset edge aborts the operation.
  - The first edge after deassertion is IDLE behaviour.
- done is never high in two consecutive cycles.
- result changes only on a done edge or on reset.

Test Plan:
- Reset: reset=0 for 2 cycles with start=1 → result=0, busy=0, done=0 throughout; no accept.
- SLL: a=0x0000_0001, shamt=31, op=SLL, STEP=4 → busy for 9 cycles; done pulse on cycle 9; result=0x8000_0000.
- SRA/SRL: a=0x8000_00F0, shamt=4.
  - SRA → result=0xF800_000F after 2 cycles.
  - SRL → result=0x0800_000F after 2 cycles.
- ROTL and zero shift:
  - a=0x8000_0001, shamt=1, op=ROTL → result=0x0000_0003 after 2 cycles.
  - shamt=0 → result=a, done one cycle after accept.
- Handshake:
  - start pulsed while busy → ignored; result reflects only the first operation.
  - start held high with new a during the done cycle → second operation accepted that edge; two done pulses separated by its latency.
- Abort: clear=1 in the 3rd busy cycle of a shamt=20 op → busy drops next cycle, no done pulse, result retains the previous value; a new start is accepted normally afterwards.
